// File: rtl/io_axis_fifo.sv
// Single-clock AXI4-Stream FIFO with first-word-fall-through output and a registered occupancy count.
// Define IO_FIFO_PEAK_EN to build the peak_count high-water-mark register; otherwise peak_count reads 0.
module io_axis_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [31:0]           count,
  output logic                  overflow,
  output logic [31:0]           peak_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [AW:0]  wr_ptr_next, rd_ptr_next;
  logic [AW:0]  used_next;
  logic [31:0]  count_q, count_next;
  logic         s_tready_q, m_tvalid_q, overflow_q;
  logic         push, pop;
  logic         full_now, full_next, empty_next;

  // Handshakes use only registered flags, so s_tready never depends on m_tready.
  assign push = s_tvalid & s_tready_q;
  assign pop  = m_tvalid_q & m_tready;

  // Same MSB comparison as full_next, applied to the current pointers; drives overflow detection.
  assign full_now = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (push) wr_ptr_next = wr_ptr + 1'b1;
    if (pop)  rd_ptr_next = rd_ptr + 1'b1;
  end

  assign used_next  = wr_ptr_next - rd_ptr_next;
  assign count_next = 32'(used_next);
  assign full_next  = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  assign empty_next = (wr_ptr_next == rd_ptr_next);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      count_q    <= count_next;
      s_tready_q <= !full_next;
      m_tvalid_q <= !empty_next;
      if (s_tvalid && full_now) overflow_q <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone define which words are valid.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
  end

  assign m_tdata  = mem[rd_ptr[AW-1:0]];
  assign m_tvalid = m_tvalid_q;
  assign s_tready = s_tready_q;
  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef IO_FIFO_PEAK_EN
  logic [31:0] peak_q;

  // count never exceeds DEPTH, so the high-water mark saturates there on its own.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      peak_q <= '0;
    end else if (count_next > peak_q) begin
      peak_q <= count_next;
    end
  end

  assign peak_count = peak_q;
`else
  assign peak_count = '0;
`endif

endmodule

// File: tb/tb_io_axis_fifo.sv
// Self-checking bench for io_axis_fifo: a vector table for the basic handshake plus
// scoreboarded sequences for fill/drain, overflow, sustained streaming, mid-run reset and peak.
module tb_io_axis_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [31:0]   count;
  logic          overflow;
  logic [31:0]   peak_count;

  io_axis_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .count      (count),
    .overflow   (overflow),
    .peak_count (peak_count)
  );

  always #5 aclk = ~aclk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [DW-1:0] sb[$];
  int            m_count;
  logic          m_ovf;
  int            m_peak;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic [31:0]   e_count;
    logic          e_mvalid;
    logic          e_sready;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    @(posedge aclk); #1;
    check("rst_count", count, 32'd0);
    check("rst_mvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_sready", {31'd0, s_tready}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_peak", peak_count, 32'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("post_rst_sready", {31'd0, s_tready}, 32'd1);
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_peak  = 0;
  endtask

  // One clock of stimulus; the model decides the handshakes and the scoreboard checks popped data.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    logic exp_push, exp_pop;
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
    check("sready", {31'd0, s_tready}, {31'd0, m_count != DEPTH});
    check("mvalid", {31'd0, m_tvalid}, {31'd0, m_count != 0});
    exp_push = v && (m_count != DEPTH);
    exp_pop  = r && (m_count != 0);
    if (exp_pop) begin
      if (sb.size() == 0) check("sb_underrun", 32'd1, 32'd0);
      else                check("pop_data", {16'd0, m_tdata}, {16'd0, sb.pop_front()});
    end
    if (v && (m_count == DEPTH)) m_ovf = 1'b1;
    @(posedge aclk); #1;
    if (exp_push) sb.push_back(d);
    m_count = m_count + int'(exp_push) - int'(exp_pop);
`ifdef IO_FIFO_PEAK_EN
    if (m_count > m_peak) m_peak = m_count;
`endif
    check("count", count, m_count);
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("peak", peak_count, m_peak);
  endtask

  initial begin
    vecs[0] = '{v:1'b1, d:16'h1234, r:1'b0, e_count:32'd1, e_mvalid:1'b1, e_sready:1'b1, e_data:16'h1234};
    vecs[1] = '{v:1'b0, d:16'h0000, r:1'b1, e_count:32'd0, e_mvalid:1'b0, e_sready:1'b1, e_data:16'h0000};
    vecs[2] = '{v:1'b1, d:16'h00AA, r:1'b1, e_count:32'd1, e_mvalid:1'b1, e_sready:1'b1, e_data:16'h00AA};
    vecs[3] = '{v:1'b1, d:16'h00BB, r:1'b1, e_count:32'd1, e_mvalid:1'b1, e_sready:1'b1, e_data:16'h00BB};
    vecs[4] = '{v:1'b0, d:16'h0000, r:1'b1, e_count:32'd0, e_mvalid:1'b0, e_sready:1'b1, e_data:16'h0000};

    do_reset();

    // Basic handshake vectors
    for (int i = 0; i < 5; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].r);
      check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
      check($sformatf("vec%0d_mvalid", i), {31'd0, m_tvalid}, {31'd0, vecs[i].e_mvalid});
      check($sformatf("vec%0d_sready", i), {31'd0, s_tready}, {31'd0, vecs[i].e_sready});
      if (vecs[i].e_mvalid)
        check($sformatf("vec%0d_data", i), {16'd0, m_tdata}, {16'd0, vecs[i].e_data});
    end

    // Fill to capacity, then an overflow attempt that must be dropped
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0);
    check("full_count", count, 32'd32);
    check("full_sready", {31'd0, s_tready}, 32'd0);
    cycle(1'b1, 16'hDEAD, 1'b0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_count", count, 32'd32);

    // Drain in order; a write offered while still full in the first drain cycle is refused
    cycle(1'b1, 16'hBEEF, 1'b1);
    check("sready_after_pop", {31'd0, s_tready}, 32'd1);
    for (int i = 1; i < DEPTH; i++) cycle(1'b0, 16'h0000, 1'b1);
    check("drained_count", count, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset clears the sticky flag
    do_reset();

    // Sustained push+pop at count=5 across several pointer wraps
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h0500 + i), 1'b0);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, DW'(16'h1000 + i), 1'b1);
      if (count != 32'd5) check("stream_count", count, 32'd5);
    end
    check("stream_hold", count, 32'd5);
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 1'b1);
    check("stream_empty", count, 32'd0);

    // Reset in mid-operation at count=17
    for (int i = 0; i < 17; i++) cycle(1'b1, DW'(16'h2000 + i), 1'b0);
    check("mid_count", count, 32'd17);
    do_reset();
    cycle(1'b1, 16'h5A5A, 1'b0);
    check("after_rst_data", {16'd0, m_tdata}, 32'h5A5A);
    cycle(1'b0, 16'h0000, 1'b1);
    check("after_rst_empty", count, 32'd0);

    // High-water mark: push 20, pop 15, push 3
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, DW'(16'h3000 + i), 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++)  cycle(1'b1, DW'(16'h4000 + i), 1'b0);
    check("peak_final_count", count, 32'd8);
`ifdef IO_FIFO_PEAK_EN
    check("peak_final", peak_count, 32'd20);
`else
    check("peak_final", peak_count, 32'd0);
`endif
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0000, 1'b1);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
